// File: rtl/nios_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM,
// with a built-in fill engine that writes CLEAR_VALUE to every word.
module nios_ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8192,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,

    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,

    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] count;
    logic              last_grant;
    logic              req0, req1;
    logic              gnt0, gnt1;
    logic              arb_ok;
    logic              rvalid0, rvalid1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // reset_n gates the grant so stalled masters see waitrequest at once
    assign arb_ok = reset_n && (state == ARB) && !clear_start;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_ok) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign clear_busy = (state == CLEAR);
    assign clear_done = clear_busy && (count == LAST);

    always_comb begin
        ram_address    = '0;
        ram_byteenable = 4'h0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        unique case (1'b1)
            clear_busy: begin
                ram_address    = count;
                ram_byteenable = 4'hF;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_writedata  = CLEAR_VALUE;
            end
            gnt0: begin
                ram_address    = m0_address;
                ram_byteenable = m0_byteenable;
                ram_chipselect = 1'b1;
                ram_write      = m0_write;
                ram_writedata  = m0_writedata;
            end
            gnt1: begin
                ram_address    = m1_address;
                ram_byteenable = m1_byteenable;
                ram_chipselect = 1'b1;
                ram_write      = m1_write;
                ram_writedata  = m1_writedata;
            end
            default: ;
        endcase
    end

    assign ram_clken        = 1'b1;
    assign m0_waitrequest   = !gnt0;
    assign m1_waitrequest   = !gnt1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rvalid0;
    assign m1_readdatavalid = rvalid1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            count      <= '0;
            last_grant <= 1'b1;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            // a simultaneous read+write is a write, so no data returns
            rvalid0 <= gnt0 && !m0_write;
            rvalid1 <= gnt1 && !m1_write;
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
            end
            if (state == ARB) begin
                if (clear_start) begin
                    state <= CLEAR;
                end
            end else begin
                if (count == LAST) begin
                    count <= '0;
                    state <= ARB;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_ram_arbiter.sv
// Scoreboard bench for nios_ram_arbiter: behavioural RAM, expected
// read results queued at grant time and matched on readdatavalid.
module tb_nios_ram_arbiter;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 8192;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [3:0]    m0_byteenable = 4'hF, m1_byteenable = 4'hF;
    logic          m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          m0_waitrequest, m1_waitrequest;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [DW-1:0] ram_writedata;
    logic [DW-1:0] ram_readdata;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic          fill_pat = 1'b0;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nios_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_VALUE('0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .m1_waitrequest(m1_waitrequest),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    // synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (fill_pat) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'hC0DE0000 | 32'(i);
        end else if (ram_chipselect && ram_write) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteenable[b])
                    mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
        end
        ram_readdata <= mem[ram_address];
    end

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] got;
        if (reset_n && (m0_readdatavalid || m1_readdatavalid)) begin
            checks++;
            got = m1_readdatavalid ? m1_readdata : m0_readdata;
            if (m0_readdatavalid && m1_readdatavalid) begin
                failures++;
                $display("FAIL rvalid_both: both readdatavalid high, required one");
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: m%0d data=%h, required none",
                         m1_readdatavalid, got);
            end else begin
                e = sb.pop_front();
                if (m1_readdatavalid !== e.m || got !== e.d) begin
                    failures++;
                    $display("FAIL rd_data: got m%0d %h, required m%0d %h",
                             m1_readdatavalid, got, e.m, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic m, input logic [AW-1:0] a,
                           input logic [31:0] exp);
        if (!m) begin
            m0_address = a; m0_read = 1'b1;
        end else begin
            m1_address = a; m1_read = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ((m ? m1_waitrequest : m0_waitrequest) !== 1'b0) begin
            failures++;
            $display("FAIL rd_grant: m%0d waitrequest=1, required 0", m);
        end
        sb.push_back(exp_t'{m: m, d: exp});
        tick();
        m0_read = 1'b0;
        m1_read = 1'b0;
    endtask

    task automatic do_write(input logic m, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        if (!m) begin
            m0_address = a; m0_byteenable = be;
            m0_writedata = d; m0_write = 1'b1;
        end else begin
            m1_address = a; m1_byteenable = be;
            m1_writedata = d; m1_write = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ((m ? m1_waitrequest : m0_waitrequest) !== 1'b0 ||
            ram_write !== 1'b1 || ram_address !== a) begin
            failures++;
            $display("FAIL wr_grant: wait=%b ram_write=%b addr=%h, required 0 1 %h",
                     m ? m1_waitrequest : m0_waitrequest, ram_write,
                     ram_address, a);
        end
        tick();
        m0_write = 1'b0;
        m1_write = 1'b0;
        m0_byteenable = 4'hF;
        m1_byteenable = 4'hF;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_read = 1'b1;
        m1_write = 1'b1;
        fill_pat = 1'b1;
        @(posedge clk);
        #1 fill_pat = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
            ram_chipselect !== 1'b0 || ram_write !== 1'b0 ||
            m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 ||
            clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: wr=%b%b cs=%b w=%b rv=%b%b busy=%b done=%b, required 11 0 0 00 0 0",
                     m0_waitrequest, m1_waitrequest, ram_chipselect,
                     ram_write, m0_readdatavalid, m1_readdatavalid,
                     clear_busy, clear_done);
        end
        m0_read = 1'b0;
        m1_write = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(1'b0, 13'h0010, 4'hF, 32'hDEADBEEF);
        do_read(1'b0, 13'h0010, 32'hDEADBEEF);
    endtask

    task automatic test_byteenable();
        do_write(1'b0, 13'h0020, 4'hF, 32'h11223344);
        do_write(1'b1, 13'h0020, 4'h2, 32'h0000AB00);
        do_read(1'b1, 13'h0020, 32'h1122AB44);
    endtask

    task automatic test_round_robin();
        logic em;
        do_read(1'b1, 13'h0020, 32'h1122AB44);
        m0_address = 13'h0010; m0_read = 1'b1;
        m1_address = 13'h0020; m1_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            em = logic'(k & 1);
            @(negedge clk);
            checks++;
            if (m0_waitrequest !== em || m1_waitrequest !== !em ||
                ram_address !== (em ? 13'h0020 : 13'h0010)) begin
                failures++;
                $display("FAIL rr_grant%0d: wait=%b%b addr=%h, required %b%b",
                         k, m0_waitrequest, m1_waitrequest, ram_address,
                         em, !em);
            end
            sb.push_back(exp_t'{m: em,
                                d: em ? 32'h1122AB44 : 32'hDEADBEEF});
            tick();
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
    endtask

    task automatic test_clear();
        int errs = 0;
        int dones = 0;
        do_read(1'b1, 13'h0010, 32'hDEADBEEF);
        clear_start = 1'b1;
        m0_address = 13'h0000; m0_read = 1'b1;
        m1_address = 13'h1FFF; m1_writedata = 32'h0BAD0BAD;
        m1_write = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
            ram_chipselect !== 1'b0 || clear_busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_start_cycle: wait=%b%b cs=%b busy=%b, required 11 0 0",
                     m0_waitrequest, m1_waitrequest, ram_chipselect,
                     clear_busy);
        end
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (clear_busy !== 1'b1 || ram_address !== AW'(k) ||
                ram_write !== 1'b1 || ram_chipselect !== 1'b1 ||
                ram_byteenable !== 4'hF || ram_writedata !== '0 ||
                m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1)
                errs++;
            if (clear_done === 1'b1) begin
                dones++;
                if (k != DEPTH - 1) errs++;
            end
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL clr_sequence: %0d bad cycles, required 0", errs);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL clr_done_count: %0d, required 1", dones);
        end
        @(negedge clk);
        checks++;
        if (clear_busy !== 1'b0 || m0_waitrequest !== 1'b0 ||
            m1_waitrequest !== 1'b1) begin
            failures++;
            $display("FAIL clr_exit: busy=%b wait=%b%b, required 0 01",
                     clear_busy, m0_waitrequest, m1_waitrequest);
        end
        sb.push_back(exp_t'{m: 1'b0, d: 32'h0});
        tick();
        m0_read = 1'b0;
        m1_write = 1'b0;
        do_read(1'b0, 13'h1FFF, 32'h0);
    endtask

    task automatic test_clear_restart();
        int busy = 0;
        int dones = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            @(negedge clk);
            if (clear_busy !== 1'b1) break;
            busy++;
            if (clear_done === 1'b1) dones++;
            if (k == 50) clear_start = 1'b1;
            if (k == 51) clear_start = 1'b0;
        end
        clear_start = 1'b0;
        checks++;
        if (busy != DEPTH) begin
            failures++;
            $display("FAIL restart_len: busy %0d cycles, required %0d",
                     busy, DEPTH);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL restart_done: %0d pulses, required 1", dones);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int dones = 0;
        fill_pat = 1'b1;
        tick();
        fill_pat = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (100) @(negedge clk);
        m1_address = 13'h1FFF;
        m1_read = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0 ||
            ram_chipselect !== 1'b0 || ram_write !== 1'b0 ||
            m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
            m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b cs=%b w=%b wait=%b%b, required 0 0 0 0 11",
                     clear_busy, clear_done, ram_chipselect, ram_write,
                     m0_waitrequest, m1_waitrequest);
        end
        repeat (3) begin
            @(negedge clk);
            if (clear_done !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_no_done: %0d pulses, required 0", dones);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_grant: m1 waitrequest=%b, required 0",
                     m1_waitrequest);
        end
        sb.push_back(exp_t'{m: 1'b1, d: 32'hC0DE1FFF});
        tick();
        m1_read = 1'b0;
        do_read(1'b0, 13'h0005, 32'h0);
        do_read(1'b0, 13'h0100, 32'hC0DE0100);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_round_robin();
        test_clear();
        test_clear_restart();
        test_reset_mid_clear();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d reads outstanding, required 0",
                     sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_ram_arbiter.md
NIOS_RAM_ARBITER -- requirements
Module: nios_ram_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 13, RAM word-address width; DATA_W, default 32, data width; DEPTH, default 8192, RAM words; CLEAR_VALUE, default 0, fill word.
REQ-002 The block SHALL have these ports: clk  in  1  single clock, all logic rising-edge.
REQ-003 The block SHALL have these ports: reset_n  in  1  asynchronous assert, active-low reset.
REQ-004 The block SHALL have these ports, for each master m0/m1: mX_address in ADDR_W; mX_byteenable in 4; mX_read in 1; mX_write in 1; mX_writedata in DATA_W; mX_readdata out DATA_W; mX_readdatavalid out 1; mX_waitrequest out 1.
REQ-005 The block SHALL have these ports: clear_start in 1 (fill request pulse); clear_busy out 1; clear_done out 1 (one-cycle pulse).
REQ-006 The block SHALL have these RAM ports: ram_address out ADDR_W; ram_byteenable out 4; ram_chipselect out 1; ram_write out 1; ram_writedata out DATA_W; ram_clken out 1 (tied 1); ram_readdata in DATA_W (valid 1 cycle after the read address is presented).

Function
REQ-007 The block SHALL implement FSM states ARB and CLEAR.
REQ-008 In ARB, a master SHALL be requesting when mX_read or mX_write is 1; both asserted together is illegal and is treated as a write.
REQ-009 In ARB, at most one master SHALL be granted per cycle: a single requester is granted; with both requesting, the master not granted last is granted (round-robin); last_grant resets to m1, so m0 wins the first contention.
REQ-010 The granted master SHALL see mX_waitrequest=0 in that cycle; every requesting, non-granted master SHALL see mX_waitrequest=1; a non-requesting master SHALL see mX_waitrequest=1.
REQ-011 The grant decision and RAM drive SHALL be combinational in the grant cycle: ram_address/byteenable/writedata/write come from the granted master; ram_chipselect=1; with no grant, ram_chipselect=0 and ram_write=0.
REQ-012 last_grant SHALL update only on cycles with a grant.
REQ-013 For a granted read, mX_readdatavalid SHALL pulse exactly one cycle later for that master only; mX_readdata SHALL equal ram_readdata in that cycle; fixed read latency is 1 cycle.
REQ-014 Back-to-back reads SHALL be accepted every cycle; throughput is one access per cycle.
REQ-015 A granted write SHALL produce no readdatavalid.
REQ-016 clear_start=1 in ARB SHALL move the FSM to CLEAR on the next edge; no master is granted in the cycle clear_start is sampled.
REQ-017 In CLEAR, both mX_waitrequest SHALL be 1, and one word SHALL be written per cycle: address = counter, starting at 0, byteenable=4'hF, data=CLEAR_VALUE, ram_write=1.
REQ-018 After the write at address DEPTH-1, the counter SHALL return to 0, the FSM SHALL return to ARB, and clear_done SHALL pulse for that one cycle; a clear therefore takes exactly DEPTH cycles.
REQ-019 clear_busy SHALL be 1 exactly while in CLEAR.
REQ-020 clear_start SHALL be ignored while in CLEAR.
REQ-021 A read granted in the last ARB cycle before CLEAR SHALL still return its readdatavalid in the first CLEAR cycle.
REQ-022 The address counter SHALL be ADDR_W bits wide and SHALL compare against DEPTH-1 without overflow.

Reset
REQ-023 While reset_n=0, the block SHALL hold: FSM=ARB, counter=0, last_grant=m1, both mX_readdatavalid=0, clear_busy=0, clear_done=0, ram_chipselect=0, ram_write=0, both mX_waitrequest=1.
REQ-024 Reset asserted mid-CLEAR SHALL abort the fill immediately with no clear_done; the contents already written remain.
REQ-025 Deassertion of reset_n SHALL be synchronised externally; the first grant can occur in the first cycle after deassertion.

Verification
REQ-026 Bench scenario: m0 writes 0xDEADBEEF to 0x0010 with byteenable=0xF, then m0 reads 0x0010 -> waitrequest=0 on both accesses; m0_readdatavalid=1 one cycle after the read, with data 0xDEADBEEF.
REQ-027 Bench scenario: m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid goes only to the issuing master, 1 cycle later.
REQ-028 Bench scenario: byteenable=0x2 write of 0x0000AB00 over a word holding 0x11223344 -> readback is 0x1122AB44.
REQ-029 Bench scenario: clear_start pulse with DEPTH=8192 -> clear_busy=1 for 8192 cycles; clear_done pulses once; masters are stalled throughout; reads of 0x0000 and 0x1FFF return 0.
REQ-030 Bench scenario: reset_n pulled low 100 cycles into a clear -> all outputs take their reset values asynchronously; no clear_done occurs; after release, an m1 read is granted immediately.
REQ-031 Bench scenario: clear_start re-pulsed during CLEAR -> the clear still completes in exactly 8192 cycles, with a single clear_done.
